clut_map_rw_ctrl: RTL

- Producer end of the radmap read stream consumed by the TAS threshold block.
- Owns the clutter-map RAM. For each incoming range/doppler cell it reads the stored map value and presents the cell index, current magnitude and stored value on radmap_rd_*.
- Writes the returned thresh_dat back to the same cell address.
- Sequences frames: idle, run, drain for in-flight writebacks.

---
 rtl/clut_map_rw_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/clut_map_rw_ctrl.sv
// clut_map_rw_ctrl: clutter-map RAM read stream and in-order threshold writeback (optional stats: CLUT_MAP_STAT_EN)
module clut_map_rw_ctrl #(
  parameter int MAP_DEPTH  = 1024,
  parameter int AW         = $clog2(MAP_DEPTH),
  parameter int FIFO_DEPTH = 16,
  parameter int DRAIN_TMO  = 64
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        map_clr,
  input  logic        cell_vld,
  input  logic [15:0] cell_din,
  output logic        cell_rdy,
  output logic        radmap_rd_vld,
  output logic [15:0] radmap_rd_din1,
  output logic [15:0] radmap_rd_din2,
  output logic [15:0] radmap_rd_din3,
  input  logic        thresh_valid,
  input  logic [15:0] thresh_dat,
  output logic        frame_done,
  output logic        busy,
`ifdef CLUT_MAP_STAT_EN
  output logic        wb_err,
  output logic [AW:0] stat_wb_cnt,
  output logic [15:0] stat_max
`else
  output logic        wb_err
`endif
);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(DRAIN_TMO) + 1;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;
  state_t        r_state;
  logic [15:0]   r_mem [MAP_DEPTH];
  logic [AW-1:0] r_fifo [FIFO_DEPTH];
  logic [AW-1:0] r_cnt, r_idx1, w_wa;
  logic [FW-1:0] r_wp, r_rp;
  logic [FW:0]   r_fcnt;
  logic [TW-1:0] r_tmo;
  logic [15:0]   r_q, r_din1;
  logic          r_v1, r_seed, r_seed1;
  logic          w_acc, w_empty, w_we, w_orph, w_fin_ok, w_tmo;

  // r_v1 is the only stage between accept and FIFO push, so it counts as in-flight
  assign cell_rdy = (r_state == S_RUN) && (int'(r_fcnt) + int'(r_v1) <= FIFO_DEPTH - 3);
  assign w_acc    = cell_vld && cell_rdy;
  assign w_empty  = (r_fcnt == '0);
  // an empty FIFO with a push this cycle forwards the pushed index to the writeback
  assign w_we     = thresh_valid && (!w_empty || r_v1);
  assign w_wa     = w_empty ? r_idx1 : r_fifo[r_rp];
  assign w_orph   = thresh_valid && w_empty && !r_v1;
  assign w_fin_ok = (r_state == S_DRAIN) && w_empty && !r_v1;
  assign w_tmo    = (r_state == S_DRAIN) && !w_fin_ok && (r_tmo == TW'(DRAIN_TMO - 1));
  assign busy     = (r_state != S_IDLE);

  // Map RAM (write-first on address collision) and in-flight index storage; contents survive reset
  always_ff @(posedge sys_clk) begin
    if (w_we) r_mem[w_wa] <= thresh_dat;
    if (r_v1) r_fifo[r_wp] <= r_idx1;
    r_q <= (w_we && w_wa == r_cnt) ? thresh_dat : r_mem[r_cnt];
  end

  // Two-stage read pipeline: stage 1 aligns with RAM output, stage 2 drives the read stream
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_v1           <= 1'b0;
      r_idx1         <= '0;
      r_din1         <= '0;
      r_seed1        <= 1'b0;
      radmap_rd_vld  <= 1'b0;
      radmap_rd_din1 <= '0;
      radmap_rd_din2 <= '0;
      radmap_rd_din3 <= '0;
    end else begin
      r_v1           <= w_acc;
      r_idx1         <= r_cnt;
      r_din1         <= cell_din;
      r_seed1        <= r_seed;
      radmap_rd_vld  <= r_v1;
      radmap_rd_din1 <= 16'(r_idx1);
      radmap_rd_din2 <= r_din1;
      radmap_rd_din3 <= r_seed1 ? r_din1 : r_q;
    end
  end

  // In-flight address FIFO pointers; a drain timeout discards outstanding writebacks
  always_ff @(posedge sys_clk) begin
    if (rst || w_tmo) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_fcnt <= '0;
    end else begin
      if (r_v1) r_wp <= r_wp + 1'b1;
      if (w_we) r_rp <= r_rp + 1'b1;
      r_fcnt <= r_fcnt + (FW+1)'(r_v1) - (FW+1)'(w_we);
    end
  end

  // Frame sequencer: IDLE -> RUN -> DRAIN -> IDLE, plus seed flag and sticky error
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_tmo      <= '0;
      r_seed     <= 1'b1;
      frame_done <= 1'b0;
      wb_err     <= 1'b0;
    end else begin
      frame_done <= w_fin_ok || w_tmo;
      wb_err     <= wb_err || w_orph || w_tmo;
      r_tmo      <= (r_state == S_DRAIN) ? r_tmo + 1'b1 : '0;
      r_seed     <= map_clr || (r_seed && !w_fin_ok);
      if (r_state == S_IDLE && frame_start) begin
        r_state <= S_RUN;
        r_cnt   <= '0;
      end else if (w_acc) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == AW'(MAP_DEPTH - 1)) r_state <= S_DRAIN;
      end else if (w_fin_ok || w_tmo) begin
        r_state <= S_IDLE;
      end
    end
  end

`ifdef CLUT_MAP_STAT_EN
  logic [AW:0] r_acc_cnt, w_nxt_cnt;
  logic [15:0] r_acc_max, w_nxt_max;
  assign w_nxt_cnt = r_acc_cnt + (AW+1)'(w_we);
  assign w_nxt_max = (w_we && thresh_dat > r_acc_max) ? thresh_dat : r_acc_max;

  // Per-frame writeback statistics, published when the frame completes
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_acc_cnt   <= '0;
      r_acc_max   <= '0;
      stat_wb_cnt <= '0;
      stat_max    <= '0;
    end else begin
      r_acc_cnt <= (r_state == S_IDLE && frame_start) ? '0 : w_nxt_cnt;
      r_acc_max <= (r_state == S_IDLE && frame_start) ? '0 : w_nxt_max;
      if (w_fin_ok || w_tmo) begin
        stat_wb_cnt <= w_nxt_cnt;
        stat_max    <= w_nxt_max;
      end
    end
  end
`endif
endmodule
